// File: rtl/rf_write_arbiter_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
// Default geometry is a 32x32 register file with x0 hard-wired to the clear value.
package rf_write_arbiter_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int NREG   = 32;

  localparam logic [DATA_W-1:0] CLR_VAL  = '0;
  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/rf_rr_arb2.sv
// Two-way round-robin grant logic; purely combinational, priority flop lives in the parent.
// prio=0 favours requester 0 when both are valid, prio=1 favours requester 1.
module rf_rr_arb2 (
  input  logic i_valid0,
  input  logic i_valid1,
  input  logic i_prio,
  input  logic i_en,
  output logic o_grant0,
  output logic o_grant1
);

  assign o_grant0 = i_en & i_valid0 & (~i_valid1 | ~i_prio);
  assign o_grant1 = i_en & i_valid1 & (~i_valid0 |  i_prio);

endmodule

// File: rtl/rf_write_arbiter.sv
// Owns the register-file write port: clears every register after reset or clr_start,
// then shares the port between two requesters with round-robin arbitration.
//
// Handshake: a requester holds valid with stable addr/data until it sees ready; a write
// is accepted on any rising edge where valid & ready, and reaches rf_* one cycle later.
module rf_write_arbiter #(
  parameter int                   ADDR_W  = rf_write_arbiter_pkg::ADDR_W,
  parameter int                   DATA_W  = rf_write_arbiter_pkg::DATA_W,
  parameter int                   NREG    = rf_write_arbiter_pkg::NREG,
  parameter logic [DATA_W-1:0]    CLR_VAL = rf_write_arbiter_pkg::CLR_VAL
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clr_start,
  input  logic                          req0_valid,
  input  logic [ADDR_W-1:0]             req0_addr,
  input  logic [DATA_W-1:0]             req0_data,
  output logic                          req0_ready,
  input  logic                          req1_valid,
  input  logic [ADDR_W-1:0]             req1_addr,
  input  logic [DATA_W-1:0]             req1_data,
  output logic                          req1_ready,
  output logic                          rf_we,
  output logic [ADDR_W-1:0]             rf_wa,
  output logic [DATA_W-1:0]             rf_wd,
  output logic                          init_done,
  output rf_write_arbiter_pkg::state_t  o_dbg_state
);

  import rf_write_arbiter_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_REG  = ADDR_W'(NREG - 1);
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_clr_cnt;
  logic                r_prio;
  logic                r_we;
  logic [ADDR_W-1:0]   r_wa;
  logic [DATA_W-1:0]   r_wd;
  logic                r_init_done;

  logic                w_arb_en;
  logic                w_grant0;
  logic                w_grant1;

  // clr_start beats any pending request in the cycle it is seen.
  assign w_arb_en = (r_state == RUN) & ~clr_start;

  rf_rr_arb2 u_arb (
    .i_valid0 (req0_valid),
    .i_valid1 (req1_valid),
    .i_prio   (r_prio),
    .i_en     (w_arb_en),
    .o_grant0 (w_grant0),
    .o_grant1 (w_grant1)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= INIT;
      r_clr_cnt   <= '0;
      r_prio      <= 1'b0;
      r_we        <= 1'b0;
      r_wa        <= '0;
      r_wd        <= '0;
      r_init_done <= 1'b0;
    end else begin
      case (r_state)
        INIT: begin
          r_we <= 1'b1;
          r_wa <= r_clr_cnt;
          r_wd <= CLR_VAL;
          if (r_clr_cnt == LAST_REG) begin
            r_state     <= RUN;
            r_init_done <= 1'b1;
            r_clr_cnt   <= '0;
          end else begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
          end
        end
        RUN: begin
          if (clr_start) begin
            r_state     <= INIT;
            r_clr_cnt   <= '0;
            r_init_done <= 1'b0;
            r_we        <= 1'b0;
          end else if (w_grant0) begin
            // x0 writes complete the handshake but never reach the register file.
            r_we   <= (req0_addr != ZERO_ADDR);
            r_wa   <= req0_addr;
            r_wd   <= req0_data;
            r_prio <= 1'b1;
          end else if (w_grant1) begin
            r_we   <= (req1_addr != ZERO_ADDR);
            r_wa   <= req1_addr;
            r_wd   <= req1_data;
            r_prio <= 1'b0;
          end else begin
            r_we <= 1'b0;
          end
        end
        default: r_state <= INIT;
      endcase
    end
  end

  assign req0_ready  = w_grant0;
  assign req1_ready  = w_grant1;
  assign rf_we       = r_we;
  assign rf_wa       = r_wa;
  assign rf_wd       = r_wd;
  assign init_done   = r_init_done;
  assign o_dbg_state = r_state;

endmodule
